melody_sequencer: RTL and testbench

//  Plays a melody by driving the programmable tone divider. It walks a melody ROM of
//  {note, duration} bytes and presents the divisor for each note. It gates the tone

---
 rtl/melody_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_melody_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// ---------------------------------------------------------------------------
// melody_sequencer
//
// Walks a melody ROM of {note, duration} bytes and drives the programmable
// tone divider of the music box. For every note it presents the divide ratio,
// gates the tone for the note length minus a short articulation gap, and then
// moves on to the next ROM entry. Busy/done are reported to the button/LED
// logic at the top level.
//
// Parameters
//   ADDR_W       melody ROM address width (DEPTH = 2**ADDR_W entries)
//   UNIT_CYCLES  clk cycles per duration unit
//   GAP_CYCLES   silent cycles at the end of every note (< UNIT_CYCLES)
//
// Ports
//   clk       in   1       system clock
//   rst       in   1       asynchronous reset, active-high
//   start     in   1       level, sampled in IDLE only; plays from address 0
//   stop      in   1       level, aborts playback from any state
//   loop      in   1       at end of melody: 1 = restart, 0 = finish
//   rom_addr  out  ADDR_W  registered melody ROM address
//   rom_data  in   8       ROM word, valid one cycle after rom_addr
//                          [7:4] = note, [3:0] = duration in units
//   divisor   out  16      divide ratio for the tone divider, held between notes
//   tone_on   out  1       tone gate (1 = audible)
//   busy      out  1       1 in every state except IDLE
//   done      out  1       one-cycle pulse when a non-looping melody ends
// ---------------------------------------------------------------------------
module melody_sequencer #(
  parameter int ADDR_W      = 5,
  parameter int UNIT_CYCLES = 750000,
  parameter int GAP_CYCLES  = 60000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [15:0]       divisor,
  output logic              tone_on,
  output logic              busy,
  output logic              done
);

  // Wide enough for the longest note (15 units) at the given unit length.
  localparam int CNT_W = $clog2(15 * UNIT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    GAP
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] rom_addr_n;
  logic [15:0]       divisor_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              audible, audible_n;
  logic              done_n;

  logic [3:0]        note;
  logic [3:0]        dur;
  logic              last_entry;
  logic              melody_end;

  assign note       = rom_data[7:4];
  assign dur        = rom_data[3:0];
  assign last_entry = (rom_addr == {ADDR_W{1'b1}});

  // Divide ratios for a 12 MHz clock, Do (1) up to Si (12).
  function automatic logic [15:0] note_divisor(input logic [3:0] n);
    logic [15:0] d;
    case (n)
      4'd1:    d = 16'd45801;
      4'd2:    d = 16'd43293;
      4'd3:    d = 16'd40864;
      4'd4:    d = 16'd38569;
      4'd5:    d = 16'd36404;
      4'd6:    d = 16'd34361;
      4'd7:    d = 16'd32433;
      4'd8:    d = 16'd30612;
      4'd9:    d = 16'd28895;
      4'd10:   d = 16'd27273;
      4'd11:   d = 16'd25742;
      4'd12:   d = 16'd24297;
      default: d = 16'd0;
    endcase
    return d;
  endfunction

  // Notes 0 and 13..15 are rests.
  function automatic logic note_audible(input logic [3:0] n);
    return (n >= 4'd1) && (n <= 4'd12);
  endfunction

  // Sounding part of a note; the gap is carved out of the note length so the
  // overall tempo stays dur * UNIT_CYCLES (plus fetch overhead).
  function automatic logic [CNT_W-1:0] play_len(input logic [3:0] d);
    return CNT_W'(d) * CNT_W'(UNIT_CYCLES) - CNT_W'(GAP_CYCLES);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      divisor  <= '0;
      cnt      <= '0;
      audible  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      rom_addr <= rom_addr_n;
      divisor  <= divisor_n;
      cnt      <= cnt_n;
      audible  <= audible_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    rom_addr_n = rom_addr;
    divisor_n  = divisor;
    cnt_n      = cnt;
    audible_n  = audible;
    done_n     = 1'b0;
    melody_end = 1'b0;

    if (stop && (state != IDLE)) begin
      state_n    = IDLE;
      rom_addr_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state_n    = FETCH;
            rom_addr_n = '0;
          end
        end

        FETCH: begin
          state_n = LOAD;
        end

        LOAD: begin
          if (rom_data == 8'h00) begin
            melody_end = 1'b1;
          end else if (dur == 4'd0) begin
            // A skip on the final entry cannot advance without wrapping,
            // so it ends the melody instead.
            if (last_entry) begin
              melody_end = 1'b1;
            end else begin
              rom_addr_n = rom_addr + ADDR_W'(1);
              state_n    = FETCH;
            end
          end else begin
            if (note_audible(note)) begin
              divisor_n = note_divisor(note);
            end
            audible_n = note_audible(note);
            cnt_n     = play_len(dur);
            state_n   = PLAY;
          end
        end

        PLAY: begin
          if (cnt == CNT_W'(1)) begin
            cnt_n   = CNT_W'(GAP_CYCLES);
            state_n = GAP;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end

        GAP: begin
          if (cnt == CNT_W'(1)) begin
            if (last_entry) begin
              melody_end = 1'b1;
            end else begin
              rom_addr_n = rom_addr + ADDR_W'(1);
              state_n    = FETCH;
            end
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end

        default: begin
          state_n    = IDLE;
          rom_addr_n = '0;
        end
      endcase

      // End marker or last entry: loop back to the top or report completion.
      // The address is left where the melody ended rather than wrapping.
      if (melody_end) begin
        if (loop) begin
          rom_addr_n = '0;
          state_n    = FETCH;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
    end
  end

  assign tone_on = (state == PLAY) && audible;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;

  localparam int ADDR_W = 3;
  localparam int UNIT   = 10;
  localparam int GAP    = 2;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic              loop;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [15:0]       divisor;
  logic              tone_on;
  logic              busy;
  logic              done;

  logic [7:0] rom [DEPTH];

  typedef struct {
    logic        tone;
    logic [15:0] div;
    logic        busy;
    logic        done;
    logic [2:0]  addr;
  } exp_t;

  exp_t        exp_q[$];
  int          passed = 0;
  int          total  = 0;
  logic [15:0] last_div = 16'd0;

  always #5 clk = ~clk;

  // Synchronous ROM: data appears one cycle after the address.
  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  melody_sequencer #(
    .ADDR_W(ADDR_W),
    .UNIT_CYCLES(UNIT),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .loop(loop),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .divisor(divisor),
    .tone_on(tone_on),
    .busy(busy),
    .done(done)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  function automatic logic [15:0] note_div(input logic [3:0] n);
    logic [15:0] tbl [16];
    tbl = '{16'd0, 16'd45801, 16'd43293, 16'd40864, 16'd38569, 16'd36404, 16'd34361,
            16'd32433, 16'd30612, 16'd28895, 16'd27273, 16'd25742, 16'd24297,
            16'd0, 16'd0, 16'd0};
    return tbl[n];
  endfunction

  task automatic push(input bit t, input logic [15:0] d, input bit b, input bit dn, input int a);
    exp_t e;
    e.tone = t;
    e.div  = d;
    e.busy = b;
    e.done = dn;
    e.addr = a[2:0];
    exp_q.push_back(e);
  endtask

  // Expected cycle-by-cycle timeline from the cycle after start is sampled:
  // every entry costs 2 overhead cycles, a note then sounds for
  // dur*UNIT-GAP cycles and is silent for GAP cycles.
  task automatic build(input bit lp, input int maxc, input logic [15:0] d0, input int idle_tail);
    int          i;
    logic [15:0] cd;
    bit          fin;
    bit          eom;
    logic [3:0]  nt;
    logic [3:0]  du;
    exp_q.delete();
    i   = 0;
    cd  = d0;
    fin = 1'b0;
    while (!fin && exp_q.size() < maxc) begin
      eom = 1'b0;
      nt  = rom[i][7:4];
      du  = rom[i][3:0];
      push(1'b0, cd, 1'b1, 1'b0, i);
      push(1'b0, cd, 1'b1, 1'b0, i);
      if (rom[i] == 8'h00) begin
        eom = 1'b1;
      end else if (du == 4'd0) begin
        if (i == DEPTH - 1) eom = 1'b1;
        else i++;
      end else begin
        if (nt >= 1 && nt <= 12) cd = note_div(nt);
        repeat (du * UNIT - GAP) push(nt >= 1 && nt <= 12, cd, 1'b1, 1'b0, i);
        repeat (GAP) push(1'b0, cd, 1'b1, 1'b0, i);
        if (i == DEPTH - 1) eom = 1'b1;
        else i++;
      end
      if (eom) begin
        if (lp) begin
          i = 0;
        end else begin
          push(1'b0, cd, 1'b0, 1'b1, i);
          repeat (idle_tail) push(1'b0, cd, 1'b0, 1'b0, i);
          fin = 1'b1;
        end
      end
    end
  endtask

  // Pulse (or hold) start and compare the first n expected cycles.
  task automatic play(input string name, input int n, input bit hold_start);
    int m;
    m = (n < exp_q.size()) ? n : exp_q.size();
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    for (int k = 0; k < m; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("%s tone@%0d", name, k), 16'(tone_on), 16'(exp_q[k].tone));
      check($sformatf("%s div@%0d", name, k), divisor, exp_q[k].div);
      check($sformatf("%s busy@%0d", name, k), 16'(busy), 16'(exp_q[k].busy));
      check($sformatf("%s done@%0d", name, k), 16'(done), 16'(exp_q[k].done));
      check($sformatf("%s addr@%0d", name, k), 16'(rom_addr), 16'(exp_q[k].addr));
      last_div = exp_q[k].div;
    end
  endtask

  task automatic do_stop(input string name);
    start = 1'b0;
    stop  = 1'b1;
    @(posedge clk);
    #1;
    check({name, " stop tone"}, 16'(tone_on), 16'd0);
    check({name, " stop busy"}, 16'(busy), 16'd0);
    check({name, " stop addr"}, 16'(rom_addr), 16'd0);
    check({name, " stop done"}, 16'(done), 16'd0);
    check({name, " stop div"}, divisor, last_div);
    stop = 1'b0;
  endtask

  task automatic load_rom(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    for (int j = 0; j < DEPTH; j++) rom[j] = 8'h00;
    rom[0] = a;
    rom[1] = b;
    rom[2] = c;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    loop  = 1'b0;
    for (int j = 0; j < DEPTH; j++) rom[j] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset tone", 16'(tone_on), 16'd0);
    check("reset busy", 16'(busy), 16'd0);
    check("reset done", 16'(done), 16'd0);
    check("reset addr", 16'(rom_addr), 16'd0);
    check("reset div", divisor, 16'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Do for 2 units, La for 1 unit, end.
    load_rom(8'h12, 8'hA1, 8'h00);
    loop = 1'b0;
    build(1'b0, 1000, last_div, 3);
    play("basic", 1000, 1'b0);

    // Same melody looping; start held high throughout must not restart it.
    loop = 1'b1;
    build(1'b1, 80, last_div, 0);
    play("loop", 80, 1'b1);
    do_stop("loop");

    // Rest of 3 units, then Mi.
    load_rom(8'h03, 8'h51, 8'h00);
    loop = 1'b0;
    build(1'b0, 1000, last_div, 2);
    play("rest", 1000, 1'b0);

    // Stop in the middle of the first note, then replay from the top.
    load_rom(8'h12, 8'hA1, 8'h00);
    build(1'b0, 1000, last_div, 2);
    play("stopmid", 12, 1'b0);
    do_stop("stopmid");
    build(1'b0, 1000, last_div, 2);
    play("replay", 1000, 1'b0);

    // Every entry used: the melody ends after entry 7 without wrapping.
    rom = '{8'h11, 8'h22, 8'h31, 8'h42, 8'h51, 8'hC1, 8'h71, 8'h81};
    build(1'b0, 2000, last_div, 3);
    play("full", 2000, 1'b0);

    // start and stop together in IDLE: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("startstop busy@%0d", k), 16'(busy), 16'd0);
      check($sformatf("startstop tone@%0d", k), 16'(tone_on), 16'd0);
      check($sformatf("startstop done@%0d", k), 16'(done), 16'd0);
    end
    start = 1'b0;
    stop  = 1'b0;

    // Asynchronous reset during the gap after the first note.
    load_rom(8'h12, 8'hA1, 8'h00);
    build(1'b0, 1000, last_div, 0);
    play("arst", 21, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst tone", 16'(tone_on), 16'd0);
    check("arst busy", 16'(busy), 16'd0);
    check("arst done", 16'(done), 16'd0);
    check("arst addr", 16'(rom_addr), 16'd0);
    check("arst div", divisor, 16'd0);
    last_div = 16'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Random melodies against the timeline model.
    for (int r = 0; r < 6; r++) begin
      logic [3:0] n;
      logic [3:0] d;
      for (int j = 0; j < DEPTH; j++) begin
        n = 4'($urandom_range(0, 15));
        d = 4'($urandom_range(0, 3));
        if (j == DEPTH - 1 && d == 4'd0 && n != 4'd0) d = 4'd1;
        rom[j] = {n, d};
      end
      loop = 1'($urandom_range(0, 1));
      if (loop) begin
        build(1'b1, 300, last_div, 0);
        play($sformatf("rnd%0d", r), 300, 1'b0);
        do_stop($sformatf("rnd%0d", r));
      end else begin
        build(1'b0, 3000, last_div, 2);
        play($sformatf("rnd%0d", r), 3000, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
